// File: rtl/gauss_pkg.sv
// Shared constants for the Gaussian pulse generator.
// SHAPE holds round(256 * exp(-(k-16)^2 / 50)) for k = 0..32. That is a Gaussian with
// sigma = 5 samples, centred on index 16 and scaled so the peak is 1.0 in Q1.8.
package gauss_pkg;

  localparam int unsigned SHAPE_LEN    = 33;
  localparam int unsigned SHAPE_CENTER = 16;
  localparam int unsigned SHAPE_FRAC   = 8;

  typedef logic [8:0] shape_t;

  // Precomputed offline so the RTL needs no real arithmetic.
  localparam shape_t SHAPE [SHAPE_LEN] = '{
    9'd2,   9'd3,   9'd5,   9'd9,   9'd14,  9'd23,  9'd35,  9'd51,
    9'd71,  9'd96,  9'd125, 9'd155, 9'd186, 9'd214, 9'd236, 9'd251,
    9'd256,
    9'd251, 9'd236, 9'd214, 9'd186, 9'd155, 9'd125, 9'd96,  9'd71,
    9'd51,  9'd35,  9'd23,  9'd14,  9'd9,   9'd5,   9'd3,   9'd2
  };

endpackage

// File: rtl/gauss_shape_rom.sv
// Combinational lookup into the Gaussian shape table.
// Ports:
//   index  - sample index 0..63
//   shape  - 9-bit shape value. Indices past the end of the table return 0.
module gauss_shape_rom
  import gauss_pkg::*;
(
  input  logic [5:0] index,
  output logic [8:0] shape
);

  // A compare chain avoids indexing the 33-entry table with a 6-bit value
  // that can point past its end.
  always_comb begin
    shape = '0;
    for (int i = 0; i < SHAPE_LEN; i++) begin
      if (index == 6'(i)) begin
        shape = SHAPE[i];
      end
    end
  end

endmodule

// File: rtl/gauss_pulse.sv
// Gaussian pulse stimulus generator.
// After DELAY cycles from reset release, the block emits one 33-sample Gaussian pulse
// with peak AMP. When PERIOD is nonzero, the pulse repeats every PERIOD cycles.
// Ports:
//   clk    - sample clock. All state changes on the rising edge.
//   reset  - asynchronous, active-high. Clears the counter and the output at once.
//   signal - registered 8-bit unsigned pulse sample.
module gauss_pulse
  import gauss_pkg::*;
#(
  parameter int unsigned AMP    = 100,
  parameter int unsigned DELAY  = 100,
  parameter int unsigned PERIOD = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] signal
);

  localparam int unsigned PulseEnd = DELAY + SHAPE_LEN;
  localparam int unsigned CntMax   = (PulseEnd > PERIOD) ? PulseEnd : PERIOD;
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DelayC      = CntW'(DELAY);
  localparam logic [CntW-1:0] EndC        = CntW'(PulseEnd);
  localparam logic [CntW-1:0] PeriodLastC = CntW'(PERIOD - 1);
  localparam logic [16:0]     AmpW        = 17'(AMP);

  if (AMP > 255) begin : g_bad_amp
    $error("gauss_pulse: AMP must be in 0..255");
  end
  if (PERIOD != 0 && PERIOD < PulseEnd) begin : g_bad_period
    $error("gauss_pulse: PERIOD must be 0 or at least DELAY+33");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW:0]   offset;
  logic            in_win;
  logic [8:0]      shape;
  logic [16:0]     prod;
  logic [7:0]      sig_d;

  // Counter next state: wrap in periodic mode, saturate in one-shot mode.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (PERIOD != 0) begin
      if (cnt_q == PeriodLastC) begin
        cnt_d = '0;
      end
    end else if (cnt_q == EndC) begin
      cnt_d = cnt_q;
    end
  end

  // One extra bit, so that cnt < DELAY shows up as a set MSB. This avoids a
  // constant compare when DELAY is 0.
  always_comb begin
    offset = {1'b0, cnt_q} - {1'b0, DelayC};
    in_win = !offset[CntW] && (offset < (CntW + 1)'(SHAPE_LEN));
  end

  gauss_shape_rom u_rom (
    .index (offset[5:0]),
    .shape (shape)
  );

  // AMP <= 255 and shape <= 256, so the product fits in 17 bits and the
  // shifted result fits in 8 bits.
  always_comb begin
    prod  = AmpW * {8'd0, shape};
    sig_d = in_win ? 8'(prod >> SHAPE_FRAC) : 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      signal <= '0;
    end else begin
      cnt_q  <= cnt_d;
      signal <= sig_d;
    end
  end

endmodule

// File: tb/tb_gauss_pulse.sv
module tb_gauss_pulse;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] s0, s1, s2, s3, s4;

  always #5 clk = ~clk;

  gauss_pulse #(.AMP(220), .DELAY(50),  .PERIOD(0))   u0 (.clk(clk), .reset(reset), .signal(s0));
  gauss_pulse #(.AMP(180), .DELAY(165), .PERIOD(0))   u1 (.clk(clk), .reset(reset), .signal(s1));
  gauss_pulse #(.AMP(60),  .DELAY(10),  .PERIOD(100)) u2 (.clk(clk), .reset(reset), .signal(s2));
  gauss_pulse #(.AMP(255), .DELAY(0),   .PERIOD(0))   u3 (.clk(clk), .reset(reset), .signal(s3));
  gauss_pulse #(.AMP(0),   .DELAY(5),   .PERIOD(0))   u4 (.clk(clk), .reset(reset), .signal(s4));

  typedef struct {
    int edge_n;
    int sel;
    int expv;
  } vec_t;

  int nvec = 0;
  int nfail = 0;
  int edge_cnt;
  bit phase1 = 1'b0;
  int bad_u0 = 0, bad_u2 = 0, bad_u3 = 0, bad_u4 = 0;
  logic [7:0] hist1 [0:255];

  // Rising edges since the last reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // Background watchers for the long quiet stretches, plus a history of u1 for symmetry.
  always @(negedge clk) begin
    if (phase1 && !reset && edge_cnt > 0) begin
      if (edge_cnt >= 84 && s0 != 8'd0) bad_u0 <= bad_u0 + 1;
      if (!(((edge_cnt - 1) % 100) >= 10 && ((edge_cnt - 1) % 100) < 43) && s2 != 8'd0)
        bad_u2 <= bad_u2 + 1;
      if (edge_cnt >= 34 && s3 != 8'd0) bad_u3 <= bad_u3 + 1;
      if (s4 != 8'd0) bad_u4 <= bad_u4 + 1;
      if (edge_cnt < 256) hist1[edge_cnt] <= s1;
    end
  end

  function automatic int pick(input int sel);
    case (sel)
      0: return int'(s0);
      1: return int'(s1);
      2: return int'(s2);
      3: return int'(s3);
      4: return int'(s4);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Leaves time at 1 unit after rising edge n (or where it is, if already there).
  task automatic goto_edge(input int n);
    int guard = 0;
    while (edge_cnt < n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (edge_cnt < n) chk("edge_timeout", edge_cnt, n);
  endtask

  vec_t vecs[$];

  initial begin
    // {edge after release, dut, expected signal}
    vecs = '{
      '{0, 0, 0}, '{0, 1, 0}, '{0, 2, 0}, '{0, 3, 0}, '{0, 4, 0},
      '{1, 3, 1}, '{1, 0, 0},
      '{6, 3, 22},
      '{10, 2, 0},
      '{15, 2, 3},
      '{17, 3, 255},
      '{21, 2, 29},
      '{27, 2, 60},
      '{33, 3, 1},
      '{34, 3, 0},
      '{44, 2, 0},
      '{49, 0, 0}, '{50, 0, 0},
      '{51, 0, 1},
      '{62, 0, 133},
      '{67, 0, 220},
      '{83, 0, 1},
      '{84, 0, 0},
      '{110, 2, 0},
      '{115, 2, 3},
      '{121, 2, 29},
      '{127, 2, 60},
      '{144, 2, 0},
      '{165, 1, 0},
      '{166, 1, 1},
      '{171, 1, 16},
      '{174, 1, 49},
      '{182, 1, 180},
      '{185, 1, 150},
      '{198, 1, 1},
      '{199, 1, 0},
      '{221, 2, 29},
      '{227, 2, 60},
      '{300, 0, 0}
    };

    #1 reset = 1'b1;
    #2;
    chk("reset_u0", int'(s0), 0);
    chk("reset_u1", int'(s1), 0);
    chk("reset_u2", int'(s2), 0);
    chk("reset_u3", int'(s3), 0);
    chk("reset_u4", int'(s4), 0);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    phase1 = 1'b1;

    foreach (vecs[i]) begin
      goto_edge(vecs[i].edge_n);
      chk($sformatf("dut%0d_edge%0d", vecs[i].sel, vecs[i].edge_n),
          pick(vecs[i].sel), vecs[i].expv);
    end

    // Long quiet run: one-shot tails must stay 0, the periodic unit must stay in its windows.
    goto_edge(1100);
    chk("u0_tail_nonzero_count", bad_u0, 0);
    chk("u2_outside_window_count", bad_u2, 0);
    chk("u3_tail_nonzero_count", bad_u3, 0);
    chk("u4_amp0_nonzero_count", bad_u4, 0);

    // The u1 pulse must be mirror-symmetric about its peak at edge 182.
    for (int d = 1; d <= 16; d++) begin
      chk($sformatf("u1_sym_d%0d", d), int'(hist1[182 - d]), int'(hist1[182 + d]));
    end

    // Reset mid-pulse: the output clears with no clock edge, and the pulse restarts after release.
    phase1 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    goto_edge(60);
    chk("u0_pre_midreset", int'(s0), 82);
    #1 reset = 1'b1;
    #1;
    chk("u0_async_clear", int'(s0), 0);
    @(posedge clk);
    #1;
    chk("u0_held_in_reset", int'(s0), 0);
    @(negedge clk);
    reset = 1'b0;
    goto_edge(50);
    chk("u0_restart_edge50", int'(s0), 0);
    goto_edge(51);
    chk("u0_restart_edge51", int'(s0), 1);
    goto_edge(67);
    chk("u0_restart_peak", int'(s0), 220);
    goto_edge(84);
    chk("u0_restart_end", int'(s0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
